// File: rtl/yari_restart_ctrl_pkg.sv
// Shared constants and types for the yari restart/flush controller.
package yari_restart_ctrl_pkg;

  localparam logic [31:0] BootPcDefault = 32'hBFC00000;
  localparam logic [31:0] IrqPcDefault  = 32'hBFC00180;

  typedef enum logic [1:0] {
    WinNone,
    WinBoot,
    WinSrc,
    WinIrq
  } win_e;

  // Index width for an n-entry encoder, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/yari_prio_enc.sv
// Parametric priority encoder: reports the lowest set index of req_i, with a valid flag.
module yari_prio_enc
  import yari_restart_ctrl_pkg::*;
#(
  parameter int unsigned  W  = 4,
  localparam int unsigned IW = idx_width(W)
) (
  input  logic [W-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/yari_restart_ctrl.sv
// Pipeline restart/flush controller: boot sequencing, age-ordered source arbitration and
// level-sensitive interrupt entry to a fixed vector.
module yari_restart_ctrl
  import yari_restart_ctrl_pkg::*;
#(
  parameter int unsigned  NSRC       = 2,
  parameter int unsigned  BOOT_DELAY = 8,
  parameter logic [31:0]  BOOT_PC    = BootPcDefault,
  parameter int unsigned  NIRQ       = 4,
  parameter logic [31:0]  IRQ_PC     = IrqPcDefault,
  localparam int unsigned NSTAGES    = NSRC + 2,
  localparam int unsigned CAUSE_W    = idx_width(NIRQ)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NSRC-1:0]      src_restart,
  input  logic [32*NSRC-1:0]   src_restart_pc,
  input  logic [NIRQ-1:0]      irq,
  input  logic                 ie,
  input  logic                 take_valid,
  input  logic                 take_delay_slot,
  input  logic [31:0]          take_pc,
  output logic                 kill,
  output logic                 boot,
  output logic                 restart,
  output logic [31:0]          restart_pc,
  output logic [NSTAGES-1:0]   flush,
  output logic                 irq_taken,
  output logic [31:0]          irq_epc,
  output logic [CAUSE_W-1:0]   irq_cause
);

  localparam int unsigned CNT_W = $clog2(BOOT_DELAY + 1);
  localparam int unsigned SRC_W = idx_width(NSRC);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NIRQ-1:0]    irq_meta_q, irq_s_q;
  logic               blk_q, blk_d;
  logic [31:0]        irq_epc_q, irq_epc_d;
  logic [CAUSE_W-1:0] irq_cause_q, irq_cause_d;

  logic [NSRC-1:0]    src_rev;
  logic               src_any;
  logic [SRC_W-1:0]   src_rev_idx, src_idx;
  logic               irq_pend;
  logic [CAUSE_W-1:0] irq_idx;
  logic               irq_ok;
  win_e               win;

  assign kill  = (cnt_q != CNT_W'(BOOT_DELAY));
  assign boot  = (cnt_q == CNT_W'(BOOT_DELAY - 1));
  assign cnt_d = kill ? cnt_q + CNT_W'(1) : cnt_q;

  // Oldest source has the highest index; reverse so the lowest-index encoder picks it.
  always_comb begin
    src_rev = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_rev[i] = src_restart[NSRC-1-i];
    end
  end

  yari_prio_enc #(
    .W (NSRC)
  ) u_src_enc (
    .req_i   (src_rev),
    .valid_o (src_any),
    .idx_o   (src_rev_idx)
  );

  assign src_idx = SRC_W'(NSRC - 1) - src_rev_idx;

  yari_prio_enc #(
    .W (NIRQ)
  ) u_irq_enc (
    .req_i   (irq_s_q),
    .valid_o (irq_pend),
    .idx_o   (irq_idx)
  );

  assign irq_ok = irq_pend & ie & ~blk_q & take_valid & ~take_delay_slot & ~kill & ~src_any;

  always_comb begin
    win = WinNone;
    if (boot) begin
      win = WinBoot;
    end else if (!kill && src_any) begin
      win = WinSrc;
    end else if (irq_ok) begin
      win = WinIrq;
    end
  end

  always_comb begin
    restart    = 1'b0;
    restart_pc = BOOT_PC;
    flush      = '0;
    irq_taken  = 1'b0;
    unique case (win)
      WinBoot: begin
        restart = 1'b1;
        flush   = '1;
      end
      WinSrc: begin
        restart    = 1'b1;
        restart_pc = src_restart_pc[32*int'(src_idx) +: 32];
        // Only stages younger than the winner's own stage are squashed.
        for (int s = 0; s < NSTAGES; s++) begin
          flush[s] = (s <= int'(src_idx) + 1);
        end
      end
      WinIrq: begin
        restart    = 1'b1;
        restart_pc = IRQ_PC;
        flush      = NSTAGES'(7);
        irq_taken  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    blk_d       = blk_q;
    irq_epc_d   = irq_epc_q;
    irq_cause_d = irq_cause_q;
    if (irq_taken) begin
      blk_d       = 1'b1;
      irq_epc_d   = take_pc;
      irq_cause_d = irq_idx;
    end else if (!ie) begin
      blk_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      irq_meta_q  <= '0;
      irq_s_q     <= '0;
      blk_q       <= 1'b0;
      irq_epc_q   <= '0;
      irq_cause_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      irq_meta_q  <= irq;
      irq_s_q     <= irq_meta_q;
      blk_q       <= blk_d;
      irq_epc_q   <= irq_epc_d;
      irq_cause_q <= irq_cause_d;
    end
  end

  assign irq_epc   = irq_epc_q;
  assign irq_cause = irq_cause_q;

endmodule

// File: tb/tb_yari_restart_ctrl.sv
// Scoreboard bench for yari_restart_ctrl: stimulus queues expected restarts, a monitor checks them.
module tb_yari_restart_ctrl;

  localparam logic [31:0] BOOT_PC = 32'hBFC00000;
  localparam logic [31:0] IRQ_PC  = 32'hBFC00180;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [3:0]  flush;
    logic        taken;
  } exp_t;

  typedef struct {
    logic [31:0] epc;
    logic [1:0]  cause;
  } reg_t;

  logic        clock = 1'b0;
  logic        rst;
  logic [1:0]  src_restart;
  logic [63:0] src_restart_pc;
  logic [3:0]  irq;
  logic        ie;
  logic        take_valid;
  logic        take_delay_slot;
  logic [31:0] take_pc;
  logic        kill;
  logic        boot;
  logic        restart;
  logic [31:0] restart_pc;
  logic [3:0]  flush;
  logic        irq_taken;
  logic [31:0] irq_epc;
  logic [1:0]  irq_cause;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  reg_t reg_q[$];

  yari_restart_ctrl dut (
    .clock           (clock),
    .rst             (rst),
    .src_restart     (src_restart),
    .src_restart_pc  (src_restart_pc),
    .irq             (irq),
    .ie              (ie),
    .take_valid      (take_valid),
    .take_delay_slot (take_delay_slot),
    .take_pc         (take_pc),
    .kill            (kill),
    .boot            (boot),
    .restart         (restart),
    .restart_pc      (restart_pc),
    .flush           (flush),
    .irq_taken       (irq_taken),
    .irq_epc         (irq_epc),
    .irq_cause       (irq_cause)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every restart must match the head of the queue in cycle and content.
  initial begin
    exp_t e;
    reg_t r;
    logic taken_d;
    taken_d = 1'b0;
    forever begin
      @(negedge clock);
      if (restart === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_restart: got pc %h flush %b, none expected (cycle %0d)",
                   restart_pc, flush, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("restart_cycle", cyc, e.cyc);
          chk("restart_pc", restart_pc, e.pc);
          chk("flush", {28'd0, flush}, {28'd0, e.flush});
          chk("irq_taken", {31'd0, irq_taken}, {31'd0, e.taken});
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_restart: got none, expected pc %h (cycle %0d)", e.pc, cyc);
      end
      if (taken_d) begin
        if (reg_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_take: got epc %h, no take expected (cycle %0d)", irq_epc, cyc);
        end else begin
          r = reg_q.pop_front();
          chk("irq_epc", irq_epc, r.epc);
          chk("irq_cause", {30'd0, irq_cause}, {30'd0, r.cause});
        end
      end
      taken_d = (irq_taken === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst             = 1'b0;
    src_restart     = '0;
    src_restart_pc  = '0;
    irq             = '0;
    ie              = 1'b0;
    take_valid      = 1'b0;
    take_delay_slot = 1'b0;
    take_pc         = '0;
    step(2);
    chk("rst_kill", kill, 1);
    chk("rst_boot", boot, 0);
    chk("rst_restart", restart, 0);
    chk("rst_flush", flush, 0);
    chk("rst_irq_taken", irq_taken, 0);
    chk("rst_irq_epc", irq_epc, 0);
    chk("rst_irq_cause", irq_cause, 0);

    // Boot sequence.
    rst = 1'b1;
    r   = cyc;
    exp_q.push_back('{r + 7, BOOT_PC, 4'b1111, 1'b0});
    step(6);
    chk("boot_early", boot, 0);
    step(1);
    chk("boot_pulse", boot, 1);
    chk("kill_at_boot", kill, 1);
    step(1);
    chk("kill_after_boot", kill, 0);
    chk("boot_after", boot, 0);

    // Age arbitration between sources.
    src_restart    = 2'b11;
    src_restart_pc = {32'h200, 32'h100};
    exp_q.push_back('{cyc, 32'h200, 4'b0111, 1'b0});
    step(1);
    src_restart    = 2'b01;
    src_restart_pc = {32'h0, 32'h40};
    exp_q.push_back('{cyc, 32'h40, 4'b0011, 1'b0});
    step(1);
    src_restart    = 2'b10;
    src_restart_pc = {32'h300, 32'h0};
    exp_q.push_back('{cyc, 32'h300, 4'b0111, 1'b0});
    step(1);
    src_restart = 2'b00;
    step(1);

    // Interrupt entry through the synchroniser.
    ie         = 1'b1;
    irq        = 4'b0110;
    take_valid = 1'b1;
    take_pc    = 32'h1234;
    exp_q.push_back('{cyc + 2, IRQ_PC, 4'b0111, 1'b1});
    reg_q.push_back('{32'h1234, 2'd1});
    step(6);

    // Blocked until ie drops for a cycle.
    ie = 1'b0;
    step(1);
    ie      = 1'b1;
    take_pc = 32'h2000;
    exp_q.push_back('{cyc, IRQ_PC, 4'b0111, 1'b1});
    reg_q.push_back('{32'h2000, 2'd1});
    step(2);

    // Delay slot holds off the take; a concurrent source wins over the interrupt.
    ie  = 1'b0;
    irq = 4'b1100;
    step(1);
    ie              = 1'b1;
    take_delay_slot = 1'b1;
    step(3);
    take_delay_slot = 1'b0;
    src_restart     = 2'b10;
    src_restart_pc  = {32'h500, 32'h0};
    exp_q.push_back('{cyc, 32'h500, 4'b0111, 1'b0});
    step(1);
    src_restart = 2'b00;
    take_pc     = 32'h3000;
    exp_q.push_back('{cyc, IRQ_PC, 4'b0111, 1'b1});
    reg_q.push_back('{32'h3000, 2'd2});
    step(1);

    // Reset asserted in the middle of a take.
    ie = 1'b0;
    step(1);
    ie = 1'b1;
    #1;
    chk("take_before_reset", irq_taken, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_restart", restart, 0);
    chk("mid_rst_irq_taken", irq_taken, 0);
    chk("mid_rst_kill", kill, 1);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_irq_epc", irq_epc, 0);
    chk("mid_rst_irq_cause", irq_cause, 0);
    ie             = 1'b0;
    take_valid     = 1'b0;
    src_restart    = 2'b01;
    src_restart_pc = {32'h0, 32'h40};

    // Reboot with a source held through kill: only boot may restart.
    step(1);
    rst = 1'b1;
    r   = cyc;
    exp_q.push_back('{r + 7, BOOT_PC, 4'b1111, 1'b0});
    step(7);
    chk("reboot_pulse", boot, 1);
    step(1);
    src_restart = 2'b00;
    chk("rekill_drop", kill, 0);
    step(3);
    chk("restart_queue_drained", exp_q.size(), 0);
    chk("reg_queue_drained", reg_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/yari_restart_ctrl.md
# yari_restart_ctrl

Parametrised pipeline restart/flush controller for the yari core: sequences boot after reset, arbitrates restart requests from N pipeline stages by age, and injects level-sensitive external interrupts as a restart to a fixed vector. It generates the global `restart`/`restart_pc` to stage I and a per-stage flush vector. It replaces the hard-wired boot/X/M restart logic and adds interrupt entry.

## Interface
- `NSRC`, 2, restart sources; source k sits in stage k+2 (0=X, 1=M, …); `NSTAGES` = NSRC+2
- `BOOT_DELAY`, 8, cycles after reset release before boot (≥2)
- `BOOT_PC`, 32'hBFC00000, boot vector
- `NIRQ`, 4, interrupt lines (≥1)
- `IRQ_PC`, 32'hBFC00180, interrupt vector
- `clock`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-low
- `src_restart`  in  NSRC  restart request per source
- `src_restart_pc`  in  32*NSRC  target PC, source k in bits [32k+31:32k]
- `irq`  in  NIRQ  asynchronous level interrupts
- `ie`  in  1  global interrupt enable from status register
- `take_valid`  in  1  valid instruction in X
- `take_delay_slot`  in  1  that instruction is a delay slot
- `take_pc`  in  32  its PC
- `kill`  out  1  hold stage I idle
- `boot`  out  1  boot pulse
- `restart`  out  1  redirect fetch
- `restart_pc`  out  32  redirect target
- `flush`  out  NSTAGES  bit s invalidates stage s (0=I,1=D,2=X,…)
- `irq_taken`  out  1  interrupt entry pulse
- `irq_epc`  out  32  PC to resume at
- `irq_cause`  out  clog2(NIRQ) (min 1)  line taken

## Operation
- Boot counter `cnt` (clog2(BOOT_DELAY+1) bits): 0 at reset, +1 per cycle, saturates at BOOT_DELAY.
- `kill` = (cnt != BOOT_DELAY); `boot` = (cnt == BOOT_DELAY-1).
- While `kill`: sources and interrupts ignored; only `boot` can restart.
- `irq` → two-flop synchroniser → `irq_s`.
- Blocking flag `blk`: set on `irq_taken`; cleared in any cycle `ie` is 0. Prevents re-entry before software drops `ie`.
- Take condition `irq_ok` = |irq_s & ie & ~blk & take_valid & ~take_delay_slot & ~kill & ~(|src_restart).
- Priority, highest first: `boot`; highest-index (oldest) asserted source; interrupt.
- Boot: restart=1, restart_pc=BOOT_PC, flush all ones.
- Source k wins: restart=1, restart_pc=its PC, flush bits 0..k+1 set (stages younger than k+2). Younger requests same cycle dropped.
- Interrupt: restart=1, restart_pc=IRQ_PC, flush bits 0..2 (X instruction squashed), irq_taken=1.
- Interrupt registers: irq_epc ← take_pc, irq_cause ← lowest index set in irq_s.
- Flush bits never set for stages ≥ winning source's own stage.
- No request: restart=0, flush=0, restart_pc don't-care (drive BOOT_PC).
- Pending interrupt with a blocked take condition stays pending (level); no internal latch of `irq`.

## Timing
- Reset values: cnt=0, kill=1, boot=0, restart=0, flush=0, irq_taken=0, irq_epc=0, irq_cause=0, blk=0, synchroniser=0.
- restart/restart_pc/flush/irq_taken: combinational from inputs and state, same cycle as request.
- irq_epc/irq_cause valid from the cycle after irq_taken, held until next take.
- irq pin → earliest irq_taken: 2 cycles (synchroniser) plus take condition.
- First `boot` BOOT_DELAY-1 cycles after reset release; `kill` drops the next cycle.
- Boot and source same cycle: boot wins.
- Interrupt and any source same cycle: source wins, irq_taken=0, blk unchanged.
- irq_taken and ie=0 same cycle impossible (ie gates take); blk set wins over clear only when ie=1.
- Reset asserted mid-operation: all state to reset values immediately (async); boot sequence restarts after release.

## Structure
- Shared constants BOOT_PC, IRQ_PC default values belong in the core's common `asm.v`-style header.
- One sub-module natural: `yari_prio_enc` (parametric lowest-index priority encoder with valid), used for irq_cause and reused reversed for source arbitration.
- No other hierarchy; synchroniser inline.

## Test plan
- Release reset, no inputs, BOOT_DELAY=8 → boot=1 at cycle 7 with restart_pc=BFC00000, flush=1111; kill=0 from cycle 8.
- After boot, src_restart=2'b11, PCs 0x100 (X) / 0x200 (M) → restart_pc=0x200, flush=0111.
- Only X restart, PC 0x40 → restart_pc=0x40, flush=0011.
- ie=1, irq=4'b0110, take_valid=1, take_pc=0x1234 → irq_taken 2 cycles later, restart_pc=BFC00180, flush=0111, next cycle irq_epc=0x1234, irq_cause=1.
- irq held, ie held 1 → no second take; drop ie one cycle, raise it again → take recurs.
- Delay-slot instruction or concurrent M restart → no take until condition clears; reset asserted mid-take → all outputs to reset values same cycle.
